// File: rtl/jellyvl_cdc_handshake_arbiter.sv
// Round-robin arbiter feeding the source side of a handshake CDC: one {index, payload} word in flight at a time.
// Optional timeout monitor enabled by defining JELLYVL_CDC_HANDSHAKE_ARBITER_TIMEOUT_EN.
module jellyvl_cdc_handshake_arbiter #(
  parameter int NUM            = 4,
  parameter int WIDTH          = 32,
  parameter int IDX_WIDTH      = $clog2(NUM),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic [NUM*WIDTH-1:0]       s_data,
  input  logic [NUM-1:0]             s_valid,
  output logic [NUM-1:0]             s_ready,
  output logic [IDX_WIDTH+WIDTH-1:0] m_src_in,
  output logic                       m_src_send,
  input  logic                       m_src_rcv,
  output logic                       busy,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RCV_LOW
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] last_grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic                 grant_found;
  logic [WIDTH-1:0]     grant_data;
  logic                 accept;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM; k++) begin
      cand_idx = IDX_WIDTH'((32'(last_grant) + k) % NUM);
      if (!grant_found && s_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (grant_idx == IDX_WIDTH'(i)) grant_data = s_data[i*WIDTH +: WIDTH];
    end
  end

  // A stale acknowledge from an aborted transfer blocks new grants until it clears.
  always_comb begin
    s_ready = '0;
    if (rst && (state == IDLE) && !m_src_rcv && grant_found) s_ready[grant_idx] = 1'b1;
  end

  assign accept = |(s_ready & s_valid);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      m_src_send <= 1'b0;
      m_src_in   <= '0;
      last_grant <= IDX_WIDTH'(NUM - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_src_in   <= {grant_idx, grant_data};
            last_grant <= grant_idx;
            m_src_send <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (m_src_rcv) begin
            m_src_send <= 1'b0;
            state      <= WAIT_RCV_LOW;
          end
        end
        WAIT_RCV_LOW: begin
          if (!m_src_rcv) state <= IDLE;
        end
        default: begin
          m_src_send <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef JELLYVL_CDC_HANDSHAKE_ARBITER_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if ((state != IDLE) && (to_cnt != '1)) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (to_cnt == 16'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
    end
  end
`else
  // Monitor absent; the parameter term is always false for legal TIMEOUT_CYCLES.
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_jellyvl_cdc_handshake_arbiter.sv
// Directed bench for jellyvl_cdc_handshake_arbiter (NUM=4, WIDTH=32); the CDC side is driven by hand.
module tb_jellyvl_cdc_handshake_arbiter;

  logic         rst;
  logic         clk;
  logic [127:0] s_data;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [33:0]  m_src_in;
  logic         m_src_send;
  logic         m_src_rcv;
  logic         busy;
  logic         timeout_err;

  int errors = 0;
  int checks = 0;

  jellyvl_cdc_handshake_arbiter #(
    .NUM           (4),
    .WIDTH         (32),
    .IDX_WIDTH     (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .rst        (rst),
    .clk        (clk),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_src_in   (m_src_in),
    .m_src_send (m_src_send),
    .m_src_rcv  (m_src_rcv),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge; drives happen here, checks #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  int unsigned exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [31:0] lane_val  [4] = '{32'h1000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  logic [3:0]  exp_ready;
  logic [33:0] exp_in;

  initial begin
    rst       = 1'b0;
    s_valid   = 4'b1111;
    m_src_rcv = 1'b0;
    s_data    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1000_0000};
    step(); step(); #1;
    chk("rst_s_ready",  s_ready,     4'b0000);
    chk("rst_busy",     busy,        1'b0);
    chk("rst_send",     m_src_send,  1'b0);
    chk("rst_src_in",   m_src_in,    34'h0);
    chk("rst_timeout",  timeout_err, 1'b0);

    // Single request from requester 2.
    s_valid = 4'b0000;
    step(); rst = 1'b1;
    s_data  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1000_0000};
    s_valid = 4'b0100;
    #1;
    chk("single_ready",    s_ready,    4'b0100);
    chk("single_idle_snd", m_src_send, 1'b0);
    step(); s_valid = 4'b0000; #1;
    chk("single_ready_off", s_ready,   4'b0000);
    chk("single_send1",     m_src_send, 1'b1);
    chk("single_busy",      busy,       1'b1);
    chk("single_src_in",    m_src_in,   {2'd2, 32'hDEAD_BEEF});
    step(); #1; chk("single_send2", m_src_send, 1'b1);
    step(); #1; chk("single_send3", m_src_send, 1'b1);
    m_src_rcv = 1'b1;
    step(); #1;
    chk("single_send_drop", m_src_send, 1'b0);
    chk("single_busy_wait", busy,       1'b1);
    chk("single_src_hold",  m_src_in,   {2'd2, 32'hDEAD_BEEF});
    step(); #1; chk("single_busy_rcvhi", busy, 1'b1);
    m_src_rcv = 1'b0;
    step(); #1;
    chk("single_busy_end", busy, 1'b0);

    // Fresh reset, all four requesters held valid.
    rst = 1'b0;
    s_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1000_0000};
    step(); rst = 1'b1; s_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      #1;
      exp_ready = 4'b0001 << exp_order[t];
      exp_in    = {2'(exp_order[t]), lane_val[exp_order[t]]};
      chk($sformatf("rr_ready_%0d", t), s_ready, exp_ready);
      step(); #1;
      chk($sformatf("rr_src_in_%0d", t), m_src_in, exp_in);
      m_src_rcv = 1'b1;
      step(); #1;
      chk($sformatf("rr_wait_send_%0d", t), m_src_send, 1'b0);
      m_src_rcv = 1'b0;
      step();
    end

    // Stale acknowledge while idle: last winner was 3, so requester 0 is next.
    s_valid   = 4'b0001;
    m_src_rcv = 1'b1;
    #1;
    chk("stale_ready0", s_ready, 4'b0000);
    step(); #1;
    chk("stale_ready1", s_ready, 4'b0000);
    chk("stale_busy",   busy,    1'b0);
    m_src_rcv = 1'b0;
    #1;
    chk("stale_grant0", s_ready, 4'b0001);
    step(); #1;
    chk("stale_src_in", m_src_in, {2'd0, 32'h1000_0000});
    m_src_rcv = 1'b1; step();
    m_src_rcv = 1'b0; step();

    // Reset in the middle of SEND: winner 1, reset, then requester 0 first again.
    s_valid = 4'b1111;
    #1;
    chk("mid_pre_ready", s_ready, 4'b0010);
    step(); #1;
    chk("mid_send", m_src_send, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_send",  m_src_send, 1'b0);
    chk("mid_rst_busy",  busy,       1'b0);
    chk("mid_rst_ready", s_ready,    4'b0000);
    step(); rst = 1'b1; #1;
    chk("mid_post_ready", s_ready, 4'b0001);

    // Accept then never acknowledge.
    step(); s_valid = 4'b0000;
    repeat (4) step();
    #1;
    chk("to_early", timeout_err, 1'b0);
    repeat (16) step();
    #1;
    chk("to_send_held", m_src_send, 1'b1);
`ifdef JELLYVL_CDC_HANDSHAKE_ARBITER_TIMEOUT_EN
    chk("to_err", timeout_err, 1'b1);
`else
    chk("to_err", timeout_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
